// File: rtl/mp_window_streamer_pkg.sv
// Shared constants, FSM state type and geometry helper for the max-pool window streamer.
package mp_window_streamer_pkg;

    localparam int unsigned PIXEL_WIDTH_OUT = 8;
    localparam int unsigned WIN_SIZE        = 4;
    localparam int unsigned V_STRIDE        = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } mp_state_e;

    // First window carries 16 pixels, every later window only its new rows.
    function automatic int unsigned px_per_strip(input int unsigned img_h);
        return WIN_SIZE * WIN_SIZE + WIN_SIZE * V_STRIDE * ((img_h - WIN_SIZE) / V_STRIDE);
    endfunction

endpackage

// File: rtl/mp_window_addr_gen.sv
// Window-order address generator: walks k/row_base/col_base over 4x4 windows
// moving down by 2 rows, then across by 2 columns.
module mp_window_addr_gen
    import mp_window_streamer_pkg::*;
#(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              clr_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_in_strip_o,
    output logic              last_in_frame_o
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    logic [3:0]    r_k;
    logic          r_later;
    logic [RW-1:0] r_row_base;
    logic [CW-1:0] r_col_base;

    logic          w_k_last;
    logic          w_last_win;
    logic          w_last_strip;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;

    // Later windows fetch only rows row_base+2..row_base+3 of the current window.
    always_comb begin
        w_k_last     = r_later ? (r_k == 4'd7) : (r_k == 4'd15);
        w_last_win   = (r_row_base == RW'(IMG_H - WIN_SIZE));
        w_last_strip = (r_col_base == CW'(IMG_W - WIN_SIZE));
        if (r_later) begin
            w_row = r_row_base + RW'(V_STRIDE) + RW'(r_k[2]);
        end else begin
            w_row = r_row_base + RW'(r_k[3:2]);
        end
        w_col = r_col_base + CW'(r_k[1:0]);
    end

    assign addr_o          = ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col);
    assign last_in_strip_o = w_k_last && w_last_win;
    assign last_in_frame_o = w_k_last && w_last_win && w_last_strip;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_k        <= '0;
            r_later    <= 1'b0;
            r_row_base <= '0;
            r_col_base <= '0;
        end else if (clr_i) begin
            r_k        <= '0;
            r_later    <= 1'b0;
            r_row_base <= '0;
            r_col_base <= '0;
        end else if (advance_i) begin
            if (!w_k_last) begin
                r_k <= r_k + 4'd1;
            end else begin
                r_k <= '0;
                if (!w_last_win) begin
                    r_row_base <= r_row_base + RW'(V_STRIDE);
                    r_later    <= 1'b1;
                end else begin
                    r_row_base <= '0;
                    r_later    <= 1'b0;
                    r_col_base <= w_last_strip ? '0 : r_col_base + CW'(2);
                end
            end
        end
    end

endmodule

// File: rtl/mp_window_streamer.sv
// Frame-memory reader feeding the max-pool controller in 4x4 window order,
// framing each column strip with start_mp_o and strobing pixels with px_rdy_o.
module mp_window_streamer
    import mp_window_streamer_pkg::*;
#(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned PX_W   = PIXEL_WIDTH_OUT,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              start_frame_i,
    input  logic              stall_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [PX_W-1:0]   mem_data_i,
    output logic              start_mp_o,
    output logic              px_rdy_o,
    output logic [PX_W-1:0]   px_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    mp_state_e       r_state;
    logic            r_start_mp;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_last_strip;
    logic            r_rd_d1;
    logic            r_px_rdy;
    logic [PX_W-1:0] r_px;

    logic              w_issue;
    logic              w_clr;
    logic              w_last_in_strip;
    logic              w_last_in_frame;
    logic [ADDR_W-1:0] w_addr;

    assign w_issue = (r_state == ST_STREAM) && !stall_i;
    assign w_clr   = (r_state == ST_IDLE) && start_frame_i;

    mp_window_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i           (clk_i),
        .nreset_i        (nreset_i),
        .clr_i           (w_clr),
        .advance_i       (w_issue),
        .addr_o          (w_addr),
        .last_in_strip_o (w_last_in_strip),
        .last_in_frame_o (w_last_in_frame)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state      <= ST_IDLE;
            r_start_mp   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_last_strip <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (start_frame_i) begin
                        r_state    <= ST_START;
                        r_start_mp <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_issue && w_last_in_strip) begin
                        r_state      <= ST_DRAIN;
                        r_last_strip <= w_last_in_frame;
                    end
                end
                // Leave once the final read has been captured; px_rdy_o fires this cycle.
                ST_DRAIN: begin
                    if (!r_rd_d1) begin
                        r_start_mp <= 1'b0;
                        if (r_last_strip) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_state    <= ST_START;
                    r_start_mp <= 1'b1;
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_frame_done <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_start_mp <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_rd_d1  <= 1'b0;
            r_px_rdy <= 1'b0;
            r_px     <= '0;
        end else begin
            r_rd_d1  <= w_issue;
            r_px_rdy <= r_rd_d1;
            if (r_rd_d1) begin
                r_px <= mem_data_i;
            end
        end
    end

    assign mem_rd_o     = w_issue;
    assign mem_addr_o   = w_issue ? w_addr : '0;
    assign start_mp_o   = r_start_mp;
    assign px_rdy_o     = r_px_rdy;
    assign px_o         = r_px;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;

endmodule
